// File: rtl/popcount_frame_acc.sv
// popcount_frame_acc
//   Consumer end of a 7:3 compressor popcount path. Each beat carries LANES
//   (cout, carry, sum) triples, each worth 4*cout + 2*carry + sum (0..7).
//   Stage 1 registers the per-beat lane total. Stage 2 adds it into a
//   saturating frame accumulator. One cycle after the last beat has been
//   accumulated, the frame total is published and held until it is
//   accepted downstream.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   abort      synchronous frame abort, returns the block to its reset state
//   in_valid   input beat valid
//   in_ready   block can accept a beat
//   in_last    final beat of the frame
//   in_cout    weight-4 bit per lane
//   in_carry   weight-2 bit per lane
//   in_sum     weight-1 bit per lane
//   out_valid  frame total valid
//   out_ready  downstream accepts the total
//   out_total  saturated frame count
//   out_ovf    saturation occurred in this frame
module popcount_frame_acc #(
   parameter int LANES = 8,
   parameter int ACC_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             abort,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_last,
   input  logic [LANES-1:0] in_cout,
   input  logic [LANES-1:0] in_carry,
   input  logic [LANES-1:0] in_sum,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_total,
   output logic             out_ovf
);

   // Width that holds the largest beat value, 7*LANES.
   localparam int BV_W = $clog2(7 * LANES + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t             state_reg, state_next;
   logic               s1_valid_reg, s1_valid_next;
   logic [BV_W-1:0]    s1_val_reg, s1_val_next;
   logic               s1_last_reg, s1_last_next;
   logic [ACC_W-1:0]   acc_reg, acc_next;
   logic               ovf_reg, ovf_next;
   logic               fin_reg, fin_next;
   logic               block_reg, block_next;
   logic               out_valid_reg, out_valid_next;
   logic [ACC_W-1:0]   out_total_reg, out_total_next;
   logic               out_ovf_reg, out_ovf_next;

   // Each triple is already the binary form of the lane count.
   logic [2:0]         lane_val [LANES];
   logic [BV_W-1:0]    beat_val;
   logic               accept;
   logic [ACC_W:0]     acc_sum;
   logic               acc_sat;

   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         assign lane_val[gi] = {in_cout[gi], in_carry[gi], in_sum[gi]};
      end
   endgenerate

   always_comb begin
      beat_val = '0;
      for (int i = 0; i < LANES; i++) begin
         beat_val = beat_val + BV_W'(lane_val[i]);
      end
   end

   // block_reg is set by an accepted last beat and cleared by the output
   // handshake, so intake stays closed until the total has been taken.
   assign in_ready = !abort && !block_reg;
   assign accept   = in_valid && in_ready;

   // One extra bit lets the carry-out serve as the saturation flag.
   assign acc_sum = {1'b0, acc_reg} + (ACC_W + 1)'(s1_val_reg);
   assign acc_sat = acc_sum[ACC_W];

   always_comb begin
      state_next     = state_reg;
      s1_valid_next  = accept;
      s1_val_next    = accept ? beat_val : s1_val_reg;
      s1_last_next   = accept && in_last;
      acc_next       = acc_reg;
      ovf_next       = ovf_reg;
      fin_next       = 1'b0;
      block_next     = block_reg;
      out_valid_next = out_valid_reg;
      out_total_next = out_total_reg;
      out_ovf_next   = out_ovf_reg;

      if (s1_valid_reg) begin
         acc_next = acc_sat ? {ACC_W{1'b1}} : acc_sum[ACC_W-1:0];
         if (acc_sat) begin
            ovf_next = 1'b1;
         end
         // fin marks that the last beat has now reached the accumulator.
         fin_next = s1_last_reg;
      end

      if (accept && in_last) begin
         block_next = 1'b1;
      end

      case (state_reg)
         IDLE: begin
            if (accept) begin
               state_next = ACCUM;
            end
         end
         ACCUM: begin
            if (fin_reg) begin
               out_total_next = acc_reg;
               out_ovf_next   = ovf_reg;
               out_valid_next = 1'b1;
               state_next     = HOLD;
            end
         end
         HOLD: begin
            if (out_valid_reg && out_ready) begin
               out_valid_next = 1'b0;
               acc_next       = '0;
               ovf_next       = 1'b0;
               block_next     = 1'b0;
               state_next     = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      if (abort) begin
         state_next     = IDLE;
         s1_valid_next  = 1'b0;
         s1_val_next    = '0;
         s1_last_next   = 1'b0;
         acc_next       = '0;
         ovf_next       = 1'b0;
         fin_next       = 1'b0;
         block_next     = 1'b0;
         out_valid_next = 1'b0;
         out_total_next = '0;
         out_ovf_next   = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg     <= IDLE;
         s1_valid_reg  <= 1'b0;
         s1_val_reg    <= '0;
         s1_last_reg   <= 1'b0;
         acc_reg       <= '0;
         ovf_reg       <= 1'b0;
         fin_reg       <= 1'b0;
         block_reg     <= 1'b0;
         out_valid_reg <= 1'b0;
         out_total_reg <= '0;
         out_ovf_reg   <= 1'b0;
      end else begin
         state_reg     <= state_next;
         s1_valid_reg  <= s1_valid_next;
         s1_val_reg    <= s1_val_next;
         s1_last_reg   <= s1_last_next;
         acc_reg       <= acc_next;
         ovf_reg       <= ovf_next;
         fin_reg       <= fin_next;
         block_reg     <= block_next;
         out_valid_reg <= out_valid_next;
         out_total_reg <= out_total_next;
         out_ovf_reg   <= out_ovf_next;
      end
   end

   assign out_valid = out_valid_reg;
   assign out_total = out_total_reg;
   assign out_ovf   = out_ovf_reg;

endmodule

// File: tb/tb_popcount_frame_acc.sv
// Self-checking bench for popcount_frame_acc (LANES=8, ACC_W=8 so that
// saturation is reachable with short frames). Frame totals are predicted
// by summing lane counts with $countones and clamping to 255.
module tb_popcount_frame_acc;

   localparam int LANES = 8;
   localparam int ACC_W = 8;
   localparam int MAXV  = (1 << ACC_W) - 1;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             abort = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic             in_last = 1'b0;
   logic [LANES-1:0] in_cout = '0;
   logic [LANES-1:0] in_carry = '0;
   logic [LANES-1:0] in_sum = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [ACC_W-1:0] out_total;
   logic             out_ovf;

   int vectors = 0;
   int errors  = 0;

   popcount_frame_acc #(.LANES(LANES), .ACC_W(ACC_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .abort     (abort),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_last   (in_last),
      .in_cout   (in_cout),
      .in_carry  (in_carry),
      .in_sum    (in_sum),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_total (out_total),
      .out_ovf   (out_ovf)
   );

   always #5 clk = ~clk;

   // Reference: count carried by a set of lane bit vectors.
   function automatic int lanes_value(input logic [LANES-1:0] c,
                                      input logic [LANES-1:0] k,
                                      input logic [LANES-1:0] s);
      return 4 * $countones(c) + 2 * $countones(k) + $countones(s);
   endfunction

   // Spread a value 0..56 across lanes, up to 7 per lane.
   task automatic make_lanes(input int v, output logic [LANES-1:0] c,
                             output logic [LANES-1:0] k,
                             output logic [LANES-1:0] s);
      int rem = v;
      c = '0; k = '0; s = '0;
      for (int i = 0; i < LANES; i++) begin
         int n = (rem > 7) ? 7 : rem;
         rem -= n;
         c[i] = (n >= 4);
         k[i] = ((n % 4) >= 2);
         s[i] = (n % 2) == 1;
      end
   endtask

   // Present a beat and return #1 after the edge that accepted it.
   task automatic send_beat(input logic [LANES-1:0] c, input logic [LANES-1:0] k,
                            input logic [LANES-1:0] s, input logic last);
      int n = 0;
      in_valid = 1'b1; in_cout = c; in_carry = k; in_sum = s; in_last = last;
      while (in_ready !== 1'b1 && n < 50) begin
         @(posedge clk); #1; n++;
      end
      if (n >= 50) begin
         vectors++; errors++;
         $display("FAIL send_beat_timeout: in_ready=%b required 1", in_ready);
      end
      @(posedge clk); #1;
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic send_value(input int v, input logic last);
      logic [LANES-1:0] c, k, s;
      make_lanes(v, c, k, s);
      send_beat(c, k, s, last);
   endtask

   task automatic wait_out(output logic [ACC_W-1:0] tot, output logic ovf,
                           output bit ok);
      int n = 0;
      while (out_valid !== 1'b1 && n < 50) begin
         @(posedge clk); #1; n++;
      end
      ok  = (out_valid === 1'b1);
      tot = out_total;
      ovf = out_ovf;
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      vectors++;
      if ({in_ready, out_valid, out_total, out_ovf} !== {1'b1, 1'b0, 8'd0, 1'b0}) begin
         errors++;
         $display("FAIL reset_state: rdy=%b vld=%b tot=%0d ovf=%b required 1 0 0 0",
                  in_ready, out_valid, out_total, out_ovf);
      end
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      $display("reset: rdy=%b vld=%b tot=%0d", in_ready, out_valid, out_total);
   endtask

   task automatic test_single_beat();
      logic [LANES-1:0] ones = '1;
      send_beat(ones, ones, ones, 1'b1);
      vectors++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_after_accept: rdy=%b vld=%b required 0 0", in_ready, out_valid);
      end
      @(posedge clk); #1;
      vectors++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_early_valid: vld=%b required 0", out_valid);
      end
      @(posedge clk); #1;
      vectors++;
      if (out_valid !== 1'b1 || out_total !== 8'd56 || out_ovf !== 1'b0) begin
         errors++;
         $display("FAIL single_result: vld=%b tot=%0d ovf=%b required 1 56 0",
                  out_valid, out_total, out_ovf);
      end
      handshake();
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL single_handshake: vld=%b rdy=%b required 0 1", out_valid, in_ready);
      end
      $display("single_beat: total=56 checked");
   endtask

   task automatic test_four_beats();
      logic [LANES-1:0] z = '0, o = '1;
      logic [ACC_W-1:0] tot; logic ovf; bit ok;
      for (int b = 0; b < 4; b++) begin
         vectors++;
         if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL four_ready_beat%0d: rdy=%b required 1", b, in_ready);
         end
         send_beat(z, o, o, b == 3);
      end
      vectors++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL four_ready_after_last: rdy=%b required 0", in_ready);
      end
      wait_out(tot, ovf, ok);
      vectors++;
      if (!ok || tot !== 8'd96 || ovf !== 1'b0 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL four_result: ok=%0d tot=%0d ovf=%b rdy=%b required 1 96 0 0",
                  ok, tot, ovf, in_ready);
      end
      handshake();
      $display("four_beats: total=%0d", tot);
   endtask

   task automatic test_gaps();
      logic [ACC_W-1:0] tot; logic ovf; bit ok;
      send_value(7, 1'b0);
      send_value(0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      send_value(21, 1'b1);
      wait_out(tot, ovf, ok);
      vectors++;
      if (!ok || tot !== 8'd28 || ovf !== 1'b0) begin
         errors++;
         $display("FAIL gaps_result: ok=%0d tot=%0d ovf=%b required 1 28 0", ok, tot, ovf);
      end
      handshake();
      $display("gaps: total=%0d", tot);
   endtask

   task automatic test_backpressure();
      logic [ACC_W-1:0] tot; logic ovf; bit ok;
      logic [LANES-1:0] c, k, s;
      send_value(40, 1'b0);
      send_value(33, 1'b1);
      wait_out(tot, ovf, ok);
      vectors++;
      if (!ok || tot !== 8'd73 || ovf !== 1'b0) begin
         errors++;
         $display("FAIL bp_result: ok=%0d tot=%0d ovf=%b required 1 73 0", ok, tot, ovf);
      end
      make_lanes(50, c, k, s);
      in_valid = 1'b1; in_cout = c; in_carry = k; in_sum = s; in_last = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         vectors++;
         if (out_valid !== 1'b1 || out_total !== 8'd73 || out_ovf !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold%0d: vld=%b tot=%0d ovf=%b rdy=%b required 1 73 0 0",
                     i, out_valid, out_total, out_ovf, in_ready);
         end
      end
      handshake();
      in_valid = 1'b0; in_last = 1'b0;
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_release: vld=%b rdy=%b required 0 1", out_valid, in_ready);
      end
      send_value(9, 1'b1);
      wait_out(tot, ovf, ok);
      vectors++;
      if (!ok || tot !== 8'd9 || ovf !== 1'b0) begin
         errors++;
         $display("FAIL bp_next_frame: ok=%0d tot=%0d ovf=%b required 1 9 0", ok, tot, ovf);
      end
      handshake();
      $display("backpressure: held 73, next frame %0d", tot);
   endtask

   task automatic test_saturation();
      logic [ACC_W-1:0] tot; logic ovf; bit ok;
      for (int b = 0; b < 5; b++) send_value(56, b == 4);
      wait_out(tot, ovf, ok);
      vectors++;
      if (!ok || tot !== 8'd255 || ovf !== 1'b1) begin
         errors++;
         $display("FAIL sat_result: ok=%0d tot=%0d ovf=%b required 1 255 1", ok, tot, ovf);
      end
      handshake();
      send_value(10, 1'b1);
      wait_out(tot, ovf, ok);
      vectors++;
      if (!ok || tot !== 8'd10 || ovf !== 1'b0) begin
         errors++;
         $display("FAIL sat_next_frame: ok=%0d tot=%0d ovf=%b required 1 10 0", ok, tot, ovf);
      end
      handshake();
      $display("saturation: 280 -> 255 ovf, next frame %0d", tot);
   endtask

   task automatic test_abort();
      logic [ACC_W-1:0] tot; logic ovf; bit ok;
      logic [LANES-1:0] c, k, s;
      send_value(56, 1'b0);
      send_value(56, 1'b0);
      make_lanes(56, c, k, s);
      abort = 1'b1; in_valid = 1'b1; in_cout = c; in_carry = k; in_sum = s; in_last = 1'b1;
      #1;
      vectors++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL abort_ready: rdy=%b required 0", in_ready);
      end
      @(posedge clk); #1;
      abort = 1'b0; in_valid = 1'b0; in_last = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL abort_cleared: vld=%b rdy=%b required 0 1", out_valid, in_ready);
      end
      send_value(5, 1'b1);
      wait_out(tot, ovf, ok);
      vectors++;
      if (!ok || tot !== 8'd5 || ovf !== 1'b0) begin
         errors++;
         $display("FAIL abort_next_frame: ok=%0d tot=%0d ovf=%b required 1 5 0", ok, tot, ovf);
      end
      // Asynchronous reset while holding a result, away from any edge.
      #2;
      reset = 1'b1;
      #1;
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_total !== 8'd0) begin
         errors++;
         $display("FAIL async_reset_hold: vld=%b rdy=%b tot=%0d required 0 1 0",
                  out_valid, in_ready, out_total);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      $display("abort: next frame %0d, async reset in hold checked", tot);
   endtask

   task automatic test_random();
      logic [ACC_W-1:0] tot; logic ovf; bit ok;
      logic [LANES-1:0] c, k, s;
      for (int f = 0; f < 25; f++) begin
         int len = $urandom_range(1, 6);
         int sum = 0;
         int exp_tot;
         bit exp_ovf;
         for (int b = 0; b < len; b++) begin
            c = LANES'($urandom); k = LANES'($urandom); s = LANES'($urandom);
            sum += lanes_value(c, k, s);
            send_beat(c, k, s, b == len - 1);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #0;
         end
         exp_tot = (sum > MAXV) ? MAXV : sum;
         exp_ovf = (sum > MAXV);
         wait_out(tot, ovf, ok);
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #0;
         vectors++;
         if (!ok || int'(out_total) != exp_tot || out_ovf !== exp_ovf || tot !== out_total) begin
            errors++;
            $display("FAIL random_frame%0d: ok=%0d tot=%0d ovf=%b required 1 %0d %b",
                     f, ok, out_total, out_ovf, exp_tot, exp_ovf);
         end
         handshake();
         $display("random frame %0d: beats=%0d sum=%0d total=%0d ovf=%b",
                  f, len, sum, tot, ovf);
      end
   endtask

   initial begin
      test_reset();
      test_single_beat();
      test_four_beats();
      test_gaps();
      test_backpressure();
      test_saturation();
      test_abort();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/popcount_frame_acc.md
Name: popcount_frame_acc

Overview:
Consumer end of the 7:3 compressor popcount path. Each beat carries LANES compressor outputs, each a (cout, carry, sum) triple encoding a count of 0..7. The block resolves each triple to binary (4*cout + 2*carry + sum), sums all lanes, and accumulates over a frame delimited by in_last. It presents one saturating frame total per frame to the downstream activation/quantiser stage using a valid/ready handshake.

Parameters:
LANES, 8, number of compressor triples per beat (>=1)
ACC_W, 16, accumulator/result width (must be >= clog2(7*LANES+1))

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
abort  in  1  synchronous frame abort; clears pipeline and accumulator
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat
in_last  in  1  beat is the final beat of the frame
in_cout  in  LANES  weight-4 bit per lane
in_carry  in  LANES  weight-2 bit per lane
in_sum  in  LANES  weight-1 bit per lane
out_valid  out  1  frame total valid
out_ready  in  1  downstream accepts total
out_total  out  ACC_W  frame count, saturated
out_ovf  out  1  saturation occurred in this frame

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high (port reset).
- Reset state: in_ready=1, out_valid=0, out_total=0, out_ovf=0, stage-1 register empty, accumulator=0, FSM=IDLE. Reset may be asserted mid-frame and discards all partial state.
- Beat acceptance: a beat is accepted when in_valid && in_ready.
- Stage 1 (registered):
  - beat_val = sum over lanes of (4*in_cout[i] + 2*in_carry[i] + in_sum[i]).
  - beat_val is at most 7*LANES (56 at the default) and is computed at full width.
  - beat_val, its valid bit and in_last are captured on acceptance.
- Stage 2: when stage 1 holds a valid beat, acc <= min(acc + beat_val, 2^ACC_W - 1). The sum is computed with one extra bit; if it saturates, a sticky ovf flag is set.
- FSM states:
  - IDLE: accumulator = 0. An accepted beat moves to ACCUM. If that beat has in_last, it also arms a last-in-flight flag.
  - ACCUM: accumulation continues. When the stage-1 beat carrying last is accumulated, out_total <= final sum (saturated), out_ovf <= ovf, out_valid <= 1, and the FSM moves to HOLD.
  - HOLD: out_valid, out_total and out_ovf are stable until out_valid && out_ready. On that handshake: out_valid <= 0, acc <= 0, ovf <= 0, FSM moves to IDLE.
- in_ready:
  - 0 from the cycle after a last beat is accepted through the end of HOLD, including the handshake cycle.
  - Returns to 1 the cycle after the output handshake.
  - Otherwise 1, so the block sustains one beat per clock within a frame.
- Latency: a last beat accepted at edge T produces out_valid=1 after edge T+2.
  - A single-beat frame is legal.
  - A frame of all-zero counts yields out_total=0.
- in_valid=0 gaps inside a frame are allowed; the accumulator holds across gaps.
- abort (takes priority over everything except reset):
  - Next state is the reset state, except that out_valid is cleared even when in HOLD.
  - A beat offered in the same cycle as abort is not accepted; in_ready is forced to 0 while abort is high.
- No assertion of out_valid without a preceding last beat; exactly one output per frame.

Test Plan:
- Single beat, LANES=8, all cout=carry=sum=1, in_last=1 -> out_valid 2 cycles after accept, out_total=56, out_ovf=0.
- Four consecutive beats, per-lane triples (0,1,1) i.e. count 3, last on beat 4 -> out_total=96; in_ready held 1 for beats 1-4, then 0 until handshake.
- Frame with gaps: beats 7, 0 (all zero), gap of 3 idle cycles, then 21 with last -> out_total=28, accumulator unchanged during gaps.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> out_total/out_ovf stable, in_ready=0, in_valid beats not accepted; out_ready=1 -> next cycle out_valid=0, in_ready=1, next frame starts from 0.
- Saturation with ACC_W=8: five beats of 56 (280) -> out_total=255, out_ovf=1; following frame of one beat 10 -> out_total=10, out_ovf=0.
- abort mid-frame after two beats of 56, then a new frame of one beat 5 with last -> out_total=5; reset asserted asynchronously in HOLD -> out_valid drops immediately, in_ready=1.
